sha256_sched: RTL and testbench

// - Shares one sha256_core between NUM_REQ hash clients (ROM verify, bootloader verify, later fw-image checks).
// - Grants the core per message, not per block; round-robin between messages.
// - Issues init for a message's first block and next for later blocks; returns the digest to the owner.
// - A watchdog aborts a stalled message so a hung client cannot lock out secure boot.

---
 rtl/sha256_sched_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/sha256_sched.sv | 138 +++++++++++++
 tb/tb_sha256_sched.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_sched_pkg.sv
// Shared types and constants for the SHA-256 core scheduler.
package sha256_sched_pkg;

  localparam int BLOCK_W  = 512;
  localparam int DIGEST_W = 256;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    SETTLE  = 3'd2,
    WAIT    = 3'd3,
    DELIVER = 3'd4
  } state_t;

  // Round-robin successor of a requester index, wrapping at n.
  function automatic logic [2:0] wrap_inc(input logic [2:0] idx, input int n);
    return ((int'(idx) + 1) >= n) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping around.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic [2:0]         winner,
  output logic               found
);

  always_comb begin
    winner = 3'd0;
    found  = 1'b0;
    // Upper segment (>= ptr) has priority over the wrapped lower segment.
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j] && (3'(j) >= ptr)) begin
        found  = 1'b1;
        winner = 3'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j] && (3'(j) < ptr)) begin
        found  = 1'b1;
        winner = 3'(j);
      end
    end
  end

endmodule

// File: rtl/sha256_sched.sv
// Shares one sha256_core between NUM_REQ clients, granting per message in round-robin
// order, with a watchdog that aborts a message whose owner or core stalls.
module sha256_sched
  import sha256_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_first,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ-1:0]            req_mode,
  input  logic [NUM_REQ*BLOCK_W-1:0]    req_block,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            dig_valid,
  output logic [NUM_REQ-1:0]            dig_err,
  output logic [DIGEST_W-1:0]           dig_out,
  output logic                          busy,
  output logic [2:0]                    grant_id,
  output logic                          core_init,
  output logic                          core_next,
  output logic                          core_mode,
  output logic [BLOCK_W-1:0]            core_block,
  input  logic                          core_ready,
  input  logic [DIGEST_W-1:0]           core_digest
);

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  // Handshake: a block transfers in the cycle where req_valid[i] and req_ready[i]
  // are both high; req_ready is a same-cycle combinational pulse to the owner only.
  state_t             state, state_next;
  logic [2:0]         owner, rr_ptr, arb_winner;
  logic               arb_found;
  logic               first_q, last_q, mode_q;
  logic [WD_W-1:0]    wd_cnt;
  logic               wd_hit, fire, abort;
  logic               own_valid, own_last, cand_mode;
  logic [BLOCK_W-1:0] own_block;
  logic [NUM_REQ-1:0] owner_oh;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (req_valid & req_first),
    .ptr    (rr_ptr),
    .winner (arb_winner),
    .found  (arb_found)
  );

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_block = '0;
    cand_mode = 1'b1;
    owner_oh  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_oh[i] = (owner == 3'(i));
      if (owner == 3'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_block = req_block[i*BLOCK_W +: BLOCK_W];
      end
      if (arb_winner == 3'(i)) cand_mode = req_mode[i];
    end
  end

  assign wd_hit = (TIMEOUT != 0) && (wd_cnt == WD_W'(TIMEOUT));

  always_comb begin
    state_next = state;
    fire       = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE:    if (arb_found) state_next = ISSUE;
      ISSUE: begin
        if (core_ready && own_valid) begin
          fire       = 1'b1;
          state_next = SETTLE;
        end else if (wd_hit) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      SETTLE:  state_next = WAIT;
      WAIT: begin
        if (core_ready) begin
          state_next = last_q ? DELIVER : ISSUE;
        end else if (wd_hit) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      DELIVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req_ready  = fire ? owner_oh : '0;
  assign core_init  = fire & first_q;
  assign core_next  = fire & ~first_q;
  assign core_block = (state == ISSUE) ? own_block : '0;
  assign dig_valid  = (state == DELIVER) ? owner_oh : '0;
  assign dig_err    = abort ? owner_oh : '0;
  assign busy       = (state != IDLE);
  assign grant_id   = owner;
  assign core_mode  = mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= 3'd0;
      rr_ptr  <= 3'd0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      mode_q  <= 1'b1;
      wd_cnt  <= '0;
      dig_out <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) wd_cnt <= '0;
      else if ((state == ISSUE) || (state == WAIT)) wd_cnt <= wd_cnt + WD_W'(1);
      if ((state == IDLE) && arb_found) begin
        owner   <= arb_winner;
        mode_q  <= cand_mode;
        first_q <= 1'b1;
      end
      if (fire) begin
        first_q <= 1'b0;
        last_q  <= own_last;
      end
      // Capture while the core still holds ready so dig_out is valid alongside dig_valid.
      if ((state == WAIT) && core_ready && last_q) dig_out <= core_digest;
      if ((state == DELIVER) || abort) rr_ptr <= wrap_inc(owner, NUM_REQ);
    end
  end

endmodule

// File: tb/tb_sha256_sched.sv
// Bench for sha256_sched: behavioural SHA-256 core, per-requester drivers, and a
// scoreboard monitor comparing each digest/abort delivery against expected entries.
module tb_sha256_sched;
  localparam int NUM_REQ = 2;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [NUM_REQ-1:0]     req_valid, req_first, req_last, req_mode;
  logic [NUM_REQ*512-1:0] req_block;
  logic [NUM_REQ-1:0]     req_ready, dig_valid, dig_err;
  logic [255:0]           dig_out, core_digest;
  logic                   busy, core_init, core_next, core_mode, core_ready;
  logic [2:0]             grant_id;
  logic [511:0]           core_block;

  sha256_sched #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_first(req_first),
    .req_last(req_last), .req_mode(req_mode), .req_block(req_block),
    .req_ready(req_ready), .dig_valid(dig_valid), .dig_err(dig_err), .dig_out(dig_out),
    .busy(busy), .grant_id(grant_id), .core_init(core_init), .core_next(core_next),
    .core_mode(core_mode), .core_block(core_block), .core_ready(core_ready),
    .core_digest(core_digest)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- SHA-256 reference arithmetic ----------------
  logic [31:0] k_tab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_iv(input bit m);
    return m ? 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
             : 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int j = 0; j < 8; j++) v[j] = hin[255-32*j -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) +
           ((v[4] & v[5]) ^ (~v[4] & v[6])) + k_tab[i] + w[i];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) +
           ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int j = 0; j < 8; j++) r[255-32*j -: 32] = hin[255-32*j -: 32] + v[j];
    return r;
  endfunction

  // ---------------- behavioural sha256_core ----------------
  logic [255:0] core_h;
  int core_cnt;
  int done_cyc = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_ready <= 1'b1;
      core_h     <= '0;
      core_cnt   <= 0;
    end else if (core_init || core_next) begin
      core_ready <= 1'b0;
      core_cnt   <= $urandom_range(2, 6);
      core_h     <= compress(core_init ? sha_iv(core_mode) : core_h, core_block);
    end else if (!core_ready) begin
      if (core_cnt <= 1) begin
        core_ready <= 1'b1;
        done_cyc   <= cyc + 1;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end
  assign core_digest = core_ready ? core_h : {8{32'hdeadbeef}};

  // ---------------- scoreboard state ----------------
  logic [259:0] exp_q[$];   // {is_err, id[2:0], digest}
  int deliv_q[$];
  int n_checks = 0, n_err = 0;
  int n_init = 0, n_next = 0, n_rdy = 0;
  int rr_model = 0;
  int dv_cyc [NUM_REQ];
  int acc_cyc [NUM_REQ];
  logic [511:0] msg_blk [NUM_REQ][3];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] ref_digest(input int id, input int nblk, input bit mode);
    logic [255:0] h;
    h = sha_iv(mode);
    for (int b = 0; b < nblk; b++) h = compress(h, msg_blk[id][b]);
    return h;
  endfunction

  // Monitor: pops one expected entry per delivery pulse.
  initial begin
    int got_id;
    logic [259:0] e;
    forever begin
      @(negedge clk); #1;
      if (core_init || core_next) begin
        chk("init_next_exclusive", {1'b0, core_init & core_next}, 0);
        if (core_init) n_init++;
        if (core_next) n_next++;
      end
      if (|req_ready) begin
        n_rdy++;
        chk("req_ready_onehot", $countones(req_ready), 1);
      end
      if (|dig_valid || |dig_err) begin
        chk("delivery_onehot", $countones({dig_valid, dig_err}), 1);
        got_id = 0;
        for (int i = 0; i < NUM_REQ; i++) if (dig_valid[i] || dig_err[i]) got_id = i;
        if (exp_q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL unexpected_delivery: got id %0d with empty queue", got_id);
        end else begin
          e = exp_q.pop_front();
          chk("dig_kind_err", {1'b0, |dig_err}, {1'b0, e[259]});
          chk("dig_id", got_id, e[258:256]);
          if (!e[259]) chk("dig_out", dig_out, e[255:0]);
          else chk("err_latency", cyc, done_cyc + 1 + TIMEOUT);
        end
        deliv_q.push_back(got_id);
        dv_cyc[got_id] = cyc;
        rr_model = (got_id + 1) % NUM_REQ;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_msg(input int id, input int nblk, input int nsend, input bit mode,
                          input bit known, input logic [255:0] known_dig);
    bit got;
    int waited;
    @(negedge clk);
    for (int b = 0; b < nsend; b++) begin
      req_valid[id] = 1'b1;
      req_first[id] = (b == 0);
      req_last[id]  = (b == nblk - 1);
      req_mode[id]  = mode;
      req_block[id*512 +: 512] = msg_blk[id][b];
      got = 1'b0;
      waited = 0;
      while (!got && waited < 500) begin
        #2;
        got = req_ready[id];
        if (got && b == 0) acc_cyc[id] = cyc;
        @(negedge clk);
        waited++;
      end
      req_valid[id] = 1'b0;
      req_first[id] = 1'b0;
      req_last[id]  = 1'b0;
      if (!got) begin
        n_checks++; n_err++;
        $display("FAIL accept_timeout: req %0d block %0d not accepted, required accept", id, b);
        return;
      end
    end
    if (nsend == nblk) exp_q.push_back({1'b0, 3'(id), known ? known_dig : ref_digest(id, nblk, mode)});
    else exp_q.push_back({1'b1, 3'(id), 256'h0});
  endtask

  task automatic wait_drain(input string nm);
    int w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      n_checks++; n_err++;
      $display("FAIL %s_drain: %0d entries left, required 0", nm, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
    #1 chk({nm, "_idle_busy"}, busy, 0);
  endtask

  task automatic rand_blocks(input int id);
    for (int b = 0; b < 3; b++)
      for (int k = 0; k < 16; k++) msg_blk[id][b][k*32 +: 32] = $urandom();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_dig_valid"}, dig_valid, 0);
    chk({tag, "_dig_err"}, dig_err, 0);
    chk({tag, "_dig_out"}, dig_out, 0);
    chk({tag, "_core_init"}, core_init, 0);
    chk({tag, "_core_next"}, core_next, 0);
    chk({tag, "_core_mode"}, core_mode, 1);
    chk({tag, "_core_block"}, core_block, 0);
  endtask

  localparam logic [255:0] ABC_DIG = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] NIST_DIG = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  task automatic load_abc(input int id);
    msg_blk[id][0] = {32'h61626380, 416'h0, 64'h18};
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int i0, n0, r0, first_exp, w;
    bit got;
    req_valid = '0; req_first = '0; req_last = '0; req_mode = '0; req_block = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset("reset");
    @(negedge clk) rst_n = 1'b1;
    rr_model = 0;

    // Contention straight after reset, then again once the pointer has moved on.
    for (int rep = 0; rep < 2; rep++) begin
      if (rep == 1) begin
        load_abc(0);
        i0 = n_init; n0 = n_next;
        send_msg(0, 1, 1, 1'b1, 1'b1, ABC_DIG);
        wait_drain("abc");
        chk("abc_init_pulses", n_init - i0, 1);
        chk("abc_next_pulses", n_next - n0, 0);
      end
      first_exp = rr_model;
      rand_blocks(0); rand_blocks(1);
      deliv_q.delete();
      fork
        send_msg(0, 1, 1, 1'($urandom_range(0, 1)), 1'b0, 256'h0);
        send_msg(1, 1, 1, 1'($urandom_range(0, 1)), 1'b0, 256'h0);
      join
      wait_drain("contend");
      chk("contend_count", deliv_q.size(), 2);
      if (deliv_q.size() == 2) begin
        chk("contend_first", deliv_q[0], first_exp);
        chk("contend_second", deliv_q[1], 1 - first_exp);
      end
    end

    // Two-block NIST vector on req1.
    msg_blk[1][0] = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
                     32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
                     32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h0};
    msg_blk[1][1] = {448'h0, 64'h1c0};
    i0 = n_init; n0 = n_next; r0 = n_rdy;
    send_msg(1, 2, 2, 1'b1, 1'b1, NIST_DIG);
    wait_drain("nist");
    chk("nist_init_pulses", n_init - i0, 1);
    chk("nist_next_pulses", n_next - n0, 1);
    chk("nist_ready_pulses", n_rdy - r0, 2);

    // Lockout: req1 waits behind req0's two-block message, then wins in IDLE.
    rand_blocks(0); rand_blocks(1);
    fork
      send_msg(0, 2, 2, 1'b1, 1'b0, 256'h0);
      begin
        repeat (3) @(negedge clk);
        send_msg(1, 1, 1, 1'b0, 1'b0, 256'h0);
      end
    join
    wait_drain("lockout");
    chk("lockout_req1_accept", acc_cyc[1], dv_cyc[0] + 2);

    // Randomised traffic from both requesters.
    for (int it = 0; it < 8; it++) begin
      rand_blocks(0); rand_blocks(1);
      fork
        if ($urandom_range(0, 3) != 0) begin
          int nb0 = $urandom_range(1, 3);
          send_msg(0, nb0, nb0, 1'($urandom_range(0, 1)), 1'b0, 256'h0);
        end
        if ($urandom_range(0, 3) != 0) begin
          int nb1 = $urandom_range(1, 3);
          repeat ($urandom_range(0, 4)) @(negedge clk);
          send_msg(1, nb1, nb1, 1'($urandom_range(0, 1)), 1'b0, 256'h0);
        end
      join
      wait_drain("random");
    end

    // Timeout: req0 offers only the first of two blocks.
    rand_blocks(0);
    send_msg(0, 2, 1, 1'b1, 1'b0, 256'h0);
    wait_drain("timeout");
    chk("timeout_rr_next_is_req1", rr_model, 1);

    // Reset while the core is working on req0's first block.
    rand_blocks(0);
    @(negedge clk);
    req_valid[0] = 1'b1; req_first[0] = 1'b1; req_last[0] = 1'b0; req_mode[0] = 1'b1;
    req_block[511:0] = msg_blk[0][0];
    got = 1'b0; w = 0;
    while (!got && w < 200) begin
      #2 got = req_ready[0];
      @(negedge clk);
      w++;
    end
    req_valid[0] = 1'b0; req_first[0] = 1'b0;
    chk("midwait_accept", got, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset("midwait_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rr_model = 0;
    load_abc(0);
    send_msg(0, 1, 1, 1'b1, 1'b1, ABC_DIG);
    wait_drain("post_reset");

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "global timeout");
  end

endmodule
